// File: rtl/float_types_pkg.sv
//============================================================================
// Module      : float_types_pkg
// Description : Shared binary32 types, status codes and helpers for the
//               floating-point datapath.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package float_types_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_point_num;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_OK        = 3'd1,
        ST_INEXACT   = 3'd2,
        ST_OVERFLOW  = 3'd3,
        ST_UNDERFLOW = 3'd4,
        ST_INVALID   = 3'd5
    } fp_status_t;

    localparam int          FP_EXP_BIAS = 127;
    localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
    localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;

    // Leading-zero count of a 27-bit significand; 27 when all zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_normalize_round.sv
//============================================================================
// Module      : fp_normalize_round
// Description : Normalizes a raw sum with G/R/S bits, rounds to nearest even
//               and applies overflow/underflow handling. Subnormal results
//               are produced when FP_SUMMATOR_DENORM_EN is defined.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module fp_normalize_round
    import float_types_pkg::*;
(
    input  logic               sign,
    input  logic signed [9:0]  exp_in,
    input  logic [27:0]        sig,
    output float_point_num     result,
    output logic               overflow,
    output logic               underflow,
    output logic               inexact
);

    logic [4:0]        lz;
    logic [4:0]        shamt;
    logic [26:0]       norm;
    logic signed [9:0] exp_n;
    logic signed [9:0] exp_f;
    logic              round_up;
    logic [24:0]       rounded;

    always_comb begin
        lz    = lzc27(sig[26:0]);
        shamt = lz;
        if (sig[27]) begin
            norm  = {sig[27:2], |sig[1:0]};
            exp_n = exp_in + 10'sd1;
        end else begin
`ifdef FP_SUMMATOR_DENORM_EN
            // Stop the left shift at exponent 1 so the result stays subnormal.
            if ($signed({5'd0, lz}) >= exp_in) shamt = 5'(exp_in - 10'sd1);
`endif
            norm  = sig[26:0] << shamt;
            exp_n = exp_in - $signed({5'd0, shamt});
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded  = {1'b0, norm[26:3]} + {24'd0, round_up};

        if (rounded[24])      exp_f = exp_n + 10'sd1;
        else if (rounded[23]) exp_f = exp_n;
        else                  exp_f = 10'sd0;

        result.sign = sign;
        result.exp  = exp_f[7:0];
        result.mant = rounded[22:0];
        overflow    = 1'b0;
        underflow   = 1'b0;
        inexact     = |norm[2:0];

        if (sig == '0) begin
            result  = {sign, 31'd0};
            inexact = 1'b0;
        end else if (exp_f >= 10'sd255) begin
            result   = {sign, FP_EXP_MAX, 23'd0};
            overflow = 1'b1;
        end
`ifdef FP_SUMMATOR_DENORM_EN
        else if (!norm[26] && inexact) begin
            underflow = 1'b1;
        end
`else
        else if (exp_n < 10'sd1) begin
            result    = {sign, 31'd0};
            underflow = 1'b1;
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/fp_summator.sv
//============================================================================
// Module      : fp_summator
// Description : Binary32 adder with one-cycle registered result and status.
//               Gradual underflow enabled by FP_SUMMATOR_DENORM_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module fp_summator
    import float_types_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    input  float_point_num a_i,
    input  float_point_num b_i,
    input  logic           vld_i,
    output float_point_num answer_o,
    output fp_status_t     answer_status_o
);

    // Effective exponent and significand (hidden bit included).
    function automatic logic [31:0] unpack(input float_point_num x);
`ifdef FP_SUMMATOR_DENORM_EN
        unpack = {(x.exp == 8'd0) ? 8'd1 : x.exp, (x.exp != 8'd0), x.mant};
`else
        unpack = (x.exp == 8'd0) ? 32'd0 : {x.exp, 1'b1, x.mant};
`endif
    endfunction

    logic [31:0]    a_up, b_up;
    logic           a_nan, b_nan, a_inf, b_inf, invalid;
    logic           a_ge, eff_sub, big_sign, nr_sign;
    logic [7:0]     big_exp, small_exp, diff;
    logic [23:0]    big_sig, small_sig;
    logic [26:0]    small_ext, aligned;
    logic [27:0]    sum;
    float_point_num nr_result, res;
    logic           nr_ovf, nr_unf, nr_inx;
    fp_status_t     st;

    always_comb begin
        a_up    = unpack(a_i);
        b_up    = unpack(b_i);
        a_nan   = (a_i.exp == FP_EXP_MAX) && (a_i.mant != '0);
        b_nan   = (b_i.exp == FP_EXP_MAX) && (b_i.mant != '0);
        a_inf   = (a_i.exp == FP_EXP_MAX) && (a_i.mant == '0);
        b_inf   = (b_i.exp == FP_EXP_MAX) && (b_i.mant == '0);
        eff_sub = a_i.sign ^ b_i.sign;
        invalid = a_nan | b_nan | (a_inf & b_inf & eff_sub);

        a_ge      = a_up >= b_up;
        big_sign  = a_ge ? a_i.sign : b_i.sign;
        big_exp   = a_ge ? a_up[31:24] : b_up[31:24];
        big_sig   = a_ge ? a_up[23:0]  : b_up[23:0];
        small_exp = a_ge ? b_up[31:24] : a_up[31:24];
        small_sig = a_ge ? b_up[23:0]  : a_up[23:0];
        diff      = big_exp - small_exp;
        small_ext = {small_sig, 3'b000};

        // Bits shifted past the round position fold into the sticky bit.
        if (diff >= 8'd26)
            aligned = {26'd0, |small_sig};
        else
            aligned = (small_ext >> diff)
                    | {26'd0, |(small_ext & ~(27'h7FF_FFFF << diff))};

        if (eff_sub) sum = {1'b0, big_sig, 3'b000} - {1'b0, aligned};
        else         sum = {1'b0, big_sig, 3'b000} + {1'b0, aligned};

        nr_sign = (sum == '0 && eff_sub) ? 1'b0 : big_sign;
    end

    fp_normalize_round u_norm (
        .sign      (nr_sign),
        .exp_in    ($signed({2'b00, big_exp})),
        .sig       (sum),
        .result    (nr_result),
        .overflow  (nr_ovf),
        .underflow (nr_unf),
        .inexact   (nr_inx)
    );

    always_comb begin
        res = nr_result;
        if (nr_ovf)      st = ST_OVERFLOW;
        else if (nr_unf) st = ST_UNDERFLOW;
        else if (nr_inx) st = ST_INEXACT;
        else             st = ST_OK;

        if (invalid) begin
            res = FP_QNAN;
            st  = ST_INVALID;
        end else if (a_inf | b_inf) begin
            res = a_inf ? a_i : b_i;
            st  = ST_OK;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            answer_o        <= '0;
            answer_status_o <= ST_IDLE;
        end else if (vld_i) begin
            answer_o        <= res;
            answer_status_o <= st;
        end else begin
            answer_status_o <= ST_IDLE;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_summator.sv
//============================================================================
// Module      : tb_fp_summator
// Description : Directed-vector bench for fp_summator; expectations follow
//               FP_SUMMATOR_DENORM_EN when it is defined.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_fp_summator;
    import float_types_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ans;
        logic [2:0]  st;
    } vec_t;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           vld   = 1'b0;
    float_point_num a     = '0;
    float_point_num b     = '0;
    float_point_num ans;
    fp_status_t     st;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fp_summator dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .a_i             (a),
        .b_i             (b),
        .vld_i           (vld),
        .answer_o        (ans),
        .answer_status_o (st)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb,
                                input logic [31:0] vans, input fp_status_t vst);
        vec_t v;
        v.a = va; v.b = vb; v.ans = vans; v.st = vst;
        return v;
    endfunction

    task automatic issue(input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        a   = va;
        b   = vb;
        vld = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs.push_back(mk(32'h3F60_0000, 32'h400C_CCCD, 32'h4044_CCCD, ST_OK));
        vecs.push_back(mk(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, ST_OK));
        vecs.push_back(mk(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, ST_OK));
        vecs.push_back(mk(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, ST_INEXACT));
        vecs.push_back(mk(32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001, ST_INEXACT));
        vecs.push_back(mk(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, ST_OVERFLOW));
        vecs.push_back(mk(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, ST_INVALID));
        vecs.push_back(mk(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, ST_INVALID));
        vecs.push_back(mk(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, ST_OK));
        vecs.push_back(mk(32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000, ST_OK));
        vecs.push_back(mk(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, ST_OK));
        vecs.push_back(mk(32'h4040_0000, 32'hBF80_0000, 32'h4000_0000, ST_OK));
        vecs.push_back(mk(32'h3F80_0000, 32'hBF80_0001, 32'hB400_0000, ST_OK));
        vecs.push_back(mk(32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, ST_OK));
`ifdef FP_SUMMATOR_DENORM_EN
        vecs.push_back(mk(32'h0080_0000, 32'h8040_0000, 32'h0040_0000, ST_OK));
        vecs.push_back(mk(32'h0080_0001, 32'h8080_0000, 32'h0000_0001, ST_OK));
`else
        vecs.push_back(mk(32'h0080_0000, 32'h8040_0000, 32'h0080_0000, ST_OK));
        vecs.push_back(mk(32'h0080_0001, 32'h8080_0000, 32'h0000_0000, ST_UNDERFLOW));
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_answer", ans, 32'h0);
        check("reset_status", {29'd0, st}, {29'd0, ST_IDLE});
        @(negedge clk);
        rst_n = 1'b1;

        // Result holds with vld low, status returns to idle
        issue(32'h3F60_0000, 32'h400C_CCCD);
        check("first_answer", ans, 32'h4044_CCCD);
        check("first_status", {29'd0, st}, {29'd0, ST_OK});
        @(negedge clk);
        vld = 1'b0;
        a   = 32'h7F7F_FFFF;
        b   = 32'h7F7F_FFFF;
        @(posedge clk);
        #1;
        check("hold_answer", ans, 32'h4044_CCCD);
        check("hold_status", {29'd0, st}, {29'd0, ST_IDLE});

        // Table vectors, issued back-to-back
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_answer", i), ans, vecs[i].ans);
            check($sformatf("vec%0d_status", i), {29'd0, st}, {29'd0, vecs[i].st});
        end
        @(negedge clk);
        vld = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_table", {29'd0, st}, {29'd0, ST_IDLE});

        // Reset wins over a valid sample, then back-to-back results
        issue(32'h3F80_0000, 32'h3F80_0000);
        check("pre_reset_answer", ans, 32'h4000_0000);
        @(negedge clk);
        rst_n = 1'b0;
        a     = 32'h4040_0000;
        b     = 32'h3F80_0000;
        vld   = 1'b1;
        @(posedge clk);
        #1;
        check("rst_vld_answer", ans, 32'h0);
        check("rst_vld_status", {29'd0, st}, {29'd0, ST_IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        a     = 32'h4040_0000;
        b     = 32'hBF80_0000;
        @(posedge clk);
        #1;
        check("b2b0_answer", ans, 32'h4000_0000);
        check("b2b0_status", {29'd0, st}, {29'd0, ST_OK});
        issue(32'h3F80_0000, 32'h3380_0001);
        check("b2b1_answer", ans, 32'h3F80_0001);
        check("b2b1_status", {29'd0, st}, {29'd0, ST_INEXACT});
        @(negedge clk);
        vld = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_idle_answer", ans, 32'h3F80_0001);
        check("b2b_idle_status", {29'd0, st}, {29'd0, ST_IDLE});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
